bus_responder: RTL



---
 rtl/bus_pkg.sv | 15 +
 rtl/bus_responder_if.sv | 32 +++
 rtl/bus_resp_ram.sv | 25 ++
 rtl/bus_responder.sv | 117 +++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and defaults for the CPU-bus memory responder.
package bus_pkg;

    localparam int BUS_DATA_W = 32;
    localparam int BUS_ADDR_W = 32;
    localparam logic [31:0] BUS_FILL_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_ACK
    } state_t;

endpackage

// File: rtl/bus_responder_if.sv
// CPU memory bus as seen between the CPU (master) and one memory region (slave).
interface bus_responder_if
    import bus_pkg::*;
#(
    parameter int DATA_W = BUS_DATA_W,
    parameter int ADDR_W = BUS_ADDR_W
);

    // Four-phase handshake: the master raises i_bus_clk with we/addr/data stable,
    // the slave raises o_bus_data_ready (data valid while high), the master drops
    // i_bus_clk, then the slave drops ready. Dropping the strobe before ready aborts.
    logic              i_bus_clk;
    logic              i_bus_we;
    logic [ADDR_W-1:0] i_bus_addr;
    logic [DATA_W-1:0] i_bus_data;
    logic [DATA_W-1:0] o_bus_data;
    logic              o_bus_data_ready;
    logic              o_err;
    logic              o_busy;
    state_t            dbg_state;

    modport master (
        output i_bus_clk, i_bus_we, i_bus_addr, i_bus_data,
        input  o_bus_data, o_bus_data_ready, o_err, o_busy, dbg_state
    );

    modport slave (
        input  i_bus_clk, i_bus_we, i_bus_addr, i_bus_data,
        output o_bus_data, o_bus_data_ready, o_err, o_busy, dbg_state
    );

endinterface

// File: rtl/bus_resp_ram.sv
// Single-port synchronous RAM with registered read data; contents are never reset.
module bus_resp_ram #(
    parameter int DATA_W = 32,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bus_responder.sv
// Bus slave for one memory region: decodes a word window into internal RAM,
// inserts fixed wait states and completes a four-phase request/ready handshake.
module bus_responder
    import bus_pkg::*;
#(
    parameter int                DATA_W      = BUS_DATA_W,
    parameter int                ADDR_W      = BUS_ADDR_W,
    parameter int                MEM_AW      = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 0,
    parameter logic [DATA_W-1:0] FILL_DATA   = DATA_W'(BUS_FILL_DATA)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    bus_responder_if.slave  bus
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t              state;
    logic [3:0]          cnt;
    logic                we_q;
    logic                hit_q;
    logic [MEM_AW-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   rdata;
    logic                ready;
    logic                err;
    logic                hit;
    logic                ram_we;
    logic                ram_re;
    logic [DATA_W-1:0]   ram_q;

    assign hit = (bus.i_bus_addr >> MEM_AW) == (BASE_ADDR >> MEM_AW);

    // RAM is touched only in the single ACCESS cycle, from captured values.
    assign ram_we = (state == ST_ACCESS) && hit_q && we_q;
    assign ram_re = (state == ST_ACCESS) && hit_q && !we_q;

    bus_resp_ram #(
        .DATA_W (DATA_W),
        .AW     (MEM_AW)
    ) u_ram (
        .clk   (i_clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (addr_q),
        .wdata (data_q),
        .rdata (ram_q)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            we_q   <= 1'b0;
            hit_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            rdata  <= '0;
            ready  <= 1'b0;
            err    <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.i_bus_clk) begin
                        we_q   <= bus.i_bus_we;
                        hit_q  <= hit;
                        addr_q <= bus.i_bus_addr[MEM_AW-1:0];
                        data_q <= bus.i_bus_data;
                        cnt    <= WAIT_INIT;
                        state  <= (WAIT_INIT != 4'd0) ? ST_WAIT : ST_ACCESS;
                    end
                end
                ST_WAIT: begin
                    if (!bus.i_bus_clk) begin
                        err   <= 1'b1;
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else if (cnt == 4'd1) begin
                        cnt   <= '0;
                        state <= ST_ACCESS;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    if (!hit_q) begin
                        err <= 1'b1;
                    end
                    state <= ST_ACK;
                end
                ST_ACK: begin
                    // First ACK cycle: RAM read data has just landed, so present it with ready.
                    if (!ready) begin
                        ready <= 1'b1;
                        if (!we_q) begin
                            rdata <= hit_q ? ram_q : FILL_DATA;
                        end
                    end else if (!bus.i_bus_clk) begin
                        ready <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_bus_data       = rdata;
    assign bus.o_bus_data_ready = ready;
    assign bus.o_err            = err;
    assign bus.o_busy           = (state != ST_IDLE);
    assign bus.dbg_state        = state;

endmodule
